// File: rtl/vector_operand_sequencer.sv
// Vector operand sequencer: steps one instruction over 4-element groups, issuing register file
// addresses and a PE-latency-aligned write strobe. Optional VSEQ_STALL_EN adds a pe_stall input.
module vector_operand_sequencer #(
    parameter int unsigned PE_LATENCY = 1,
    parameter int unsigned VL_W       = 6
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start_valid,
    output logic            start_ready,
    input  logic [VL_W-1:0] vl,
    input  logic [1:0]      vsew_in,
    input  logic            widening_in,
    input  logic            uses_vs3,
    input  logic            wb_en,
    input  logic [4:0]      vs1_base,
    input  logic [4:0]      vs2_base,
    input  logic [4:0]      vd_base,
`ifdef VSEQ_STALL_EN
    input  logic            pe_stall,
`endif
    output logic [4:0]      vs1_addr,
    output logic [4:0]      vs2_addr,
    output logic [4:0]      vd_addr,
    output logic [1:0]      vsew,
    output logic            widening_op,
    output logic [1:0]      elements_to_write,
    output logic            write,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StDone} state_e;

    localparam logic [2:0] LatCnt = 3'(PE_LATENCY);

    state_e          state_q, state_d;
    logic [1:0]      vsew_q, vsew_d;
    logic            widening_q, widening_d;
    logic            vs3_q, vs3_d;
    logic            wb_en_q, wb_en_d;
    logic            err_q, err_d;
    logic [1:0]      last_e2w_q, last_e2w_d;
    logic [4:0]      vs1_q, vs1_d;
    logic [4:0]      vs2_q, vs2_d;
    logic [4:0]      vd_q, vd_d;
    logic [VL_W-1:0] grp_q, grp_d;
    logic [2:0]      cnt_q, cnt_d;

    logic            stall;
    logic            illegal_in;
    logic            advance;
    logic [VL_W:0]   vl_p3;
    logic [2:0]      vd_shift;
    logic            issuing;
    logic [7:0]      head;
    logic [7:0]      tail;

`ifdef VSEQ_STALL_EN
    assign stall = pe_stall;
`else
    assign stall = 1'b0;
`endif

    assign illegal_in = (vsew_in == 2'd3) || (widening_in && (vsew_in == 2'd2));
    assign vl_p3      = {1'b0, vl} + (VL_W+1)'(3);
    assign vd_shift   = {1'b0, vsew_q} + {2'b00, widening_q};

    always_comb begin
        state_d    = state_q;
        vsew_d     = vsew_q;
        widening_d = widening_q;
        vs3_d      = vs3_q;
        wb_en_d    = wb_en_q;
        err_d      = err_q;
        last_e2w_d = last_e2w_q;
        vs1_d      = vs1_q;
        vs2_d      = vs2_q;
        vd_d       = vd_q;
        grp_d      = grp_q;
        cnt_d      = cnt_q;
        advance    = 1'b0;

        // A stall freezes every busy state; an idle sequencer still accepts.
        if (!(stall && (state_q != StIdle))) begin
            unique case (state_q)
                StIdle: begin
                    if (start_valid) begin
                        vsew_d     = vsew_in;
                        widening_d = widening_in;
                        vs3_d      = uses_vs3;
                        wb_en_d    = wb_en;
                        err_d      = illegal_in;
                        last_e2w_d = vl[1:0];
                        vs1_d      = vs1_base;
                        vs2_d      = vs2_base;
                        vd_d       = vd_base;
                        grp_d      = VL_W'(vl_p3 >> 2);
                        if (illegal_in || (vl == '0)) state_d = StDone;
                        else                           state_d = StIssue;
                    end
                end
                StIssue: begin
                    if (vs3_q && (LatCnt != 3'd0)) begin
                        state_d = StWait;
                        cnt_d   = LatCnt;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == 3'd1) advance = 1'b1;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                StDrain: begin
                    if (cnt_q == 3'd1) state_d = StDone;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase

            if (advance) begin
                vs1_d = vs1_q + (5'd1 << vsew_q);
                vs2_d = vs2_q + (5'd1 << vsew_q);
                vd_d  = vd_q + (5'd1 << vd_shift);
                grp_d = grp_q - VL_W'(1);
                if (grp_q != VL_W'(1)) begin
                    state_d = StIssue;
                end else if (!vs3_q && (LatCnt != 3'd0)) begin
                    state_d = StDrain;
                    cnt_d   = LatCnt;
                end else begin
                    state_d = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= StIdle;
            vsew_q     <= 2'd0;
            widening_q <= 1'b0;
            vs3_q      <= 1'b0;
            wb_en_q    <= 1'b0;
            err_q      <= 1'b0;
            last_e2w_q <= 2'd0;
            vs1_q      <= 5'd0;
            vs2_q      <= 5'd0;
            vd_q       <= 5'd0;
            grp_q      <= '0;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            vsew_q     <= vsew_d;
            widening_q <= widening_d;
            vs3_q      <= vs3_d;
            wb_en_q    <= wb_en_d;
            err_q      <= err_d;
            last_e2w_q <= last_e2w_d;
            vs1_q      <= vs1_d;
            vs2_q      <= vs2_d;
            vd_q       <= vd_d;
            grp_q      <= grp_d;
            cnt_q      <= cnt_d;
        end
    end

    // Entry pushed on the first cycle of each group; in vs3 mode the tail lands on the last
    // hold cycle, so one delay line serves both modes.
    assign issuing = (state_q == StIssue) || (state_q == StWait);
    assign head    = {(state_q == StIssue) && wb_en_q, vd_q,
                      (grp_q == VL_W'(1)) ? last_e2w_q : 2'd0};

    if (PE_LATENCY == 0) begin : g_no_dl
        assign tail = head;
    end else begin : g_dl
        logic [7:0] dl_q [PE_LATENCY];
        logic [7:0] dl_d [PE_LATENCY];

        always_comb begin
            dl_d[0] = head;
            for (int i = 1; i < PE_LATENCY; i++) begin
                dl_d[i] = dl_q[i-1];
            end
            if (stall) dl_d = dl_q;
        end

        always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
                for (int i = 0; i < PE_LATENCY; i++) dl_q[i] <= 8'd0;
            end else begin
                dl_q <= dl_d;
            end
        end

        assign tail = dl_q[PE_LATENCY-1];
    end

    always_comb begin
        write             = tail[7] && !stall;
        vs1_addr          = issuing ? vs1_q : 5'd0;
        vs2_addr          = issuing ? vs2_q : 5'd0;
        elements_to_write = write ? tail[1:0] : 2'd0;
        if (vs3_q && issuing) vd_addr = vd_q;
        else if (write)       vd_addr = tail[6:2];
        else                  vd_addr = 5'd0;
        start_ready       = (state_q == StIdle);
        done              = (state_q == StDone) && !stall;
        err               = done && err_q;
        vsew              = vsew_q;
        widening_op       = widening_q;
    end

endmodule

// File: tb/tb_vector_operand_sequencer.sv
// Bench for vector_operand_sequencer: vector table plus issue/write scoreboard queues,
// hand-written reset-abort and (with VSEQ_STALL_EN) stall sequences.
module tb_vector_operand_sequencer;

    localparam int LAT  = 1;
    localparam int VL_W = 6;

    logic            clk = 1'b0;
    logic            n_reset;
    logic            start_valid;
    logic            start_ready;
    logic [VL_W-1:0] vl;
    logic [1:0]      vsew_in;
    logic            widening_in;
    logic            uses_vs3;
    logic            wb_en;
    logic [4:0]      vs1_base, vs2_base, vd_base;
    logic [4:0]      vs1_addr, vs2_addr, vd_addr;
    logic [1:0]      vsew;
    logic            widening_op;
    logic [1:0]      elements_to_write;
    logic            write;
    logic            done;
    logic            err;
`ifdef VSEQ_STALL_EN
    logic            pe_stall;
`endif

    vector_operand_sequencer #(
        .PE_LATENCY(LAT),
        .VL_W      (VL_W)
    ) dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .start_valid      (start_valid),
        .start_ready      (start_ready),
        .vl               (vl),
        .vsew_in          (vsew_in),
        .widening_in      (widening_in),
        .uses_vs3         (uses_vs3),
        .wb_en            (wb_en),
        .vs1_base         (vs1_base),
        .vs2_base         (vs2_base),
        .vd_base          (vd_base),
`ifdef VSEQ_STALL_EN
        .pe_stall         (pe_stall),
`endif
        .vs1_addr         (vs1_addr),
        .vs2_addr         (vs2_addr),
        .vd_addr          (vd_addr),
        .vsew             (vsew),
        .widening_op      (widening_op),
        .elements_to_write(elements_to_write),
        .write            (write),
        .done             (done),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vl; int vsew; bit wid; bit vs3; bit wb;
        int b1; int b2; int bd; bit poke;
        int exp_done; bit exp_err;
    } vec_t;

    typedef struct { int cyc; int a; int b; int c; } ev_t;

    vec_t vecs[10];
    ev_t  iq[$];
    ev_t  wq[$];
    int   checks = 0;
    int   errors = 0;
    int   cur = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, cur, act, exp);
        end
    endfunction

    task automatic drive(input vec_t v);
        vl          = VL_W'(v.vl);
        vsew_in     = 2'(v.vsew);
        widening_in = v.wid;
        uses_vs3    = v.vs3;
        wb_en       = v.wb;
        vs1_base    = 5'(v.b1);
        vs2_base    = 5'(v.b2);
        vd_base     = 5'(v.bd);
        start_valid = 1'b1;
    endtask

    // Called at a negedge with the DUT idle.
    task automatic run(input vec_t v);
        ev_t e;
        bit  illegal;
        bit  seen_done;
        int  g, ss, sd;
        iq.delete();
        wq.delete();
        illegal = (v.vsew == 3) || (v.wid && (v.vsew == 2));
        if (!illegal && (v.vl != 0)) begin
            g  = (v.vl + 3) / 4;
            ss = 1 << v.vsew;
            sd = 1 << (v.vsew + int'(v.wid));
            for (int i = 0; i < g; i++) begin
                e.a   = (v.b1 + i * ss) % 32;
                e.b   = (v.b2 + i * ss) % 32;
                e.c   = (v.bd + i * sd) % 32;
                e.cyc = v.vs3 ? 1 + i * (LAT + 1) : 1 + i;
                iq.push_back(e);
                if (v.wb) begin
                    e.cyc = v.vs3 ? (i + 1) * (LAT + 1) : 1 + i + LAT;
                    e.a   = (i == g - 1) ? v.vl % 4 : 0;
                    wq.push_back(e);
                end
            end
        end
        drive(v);
        chk("ready_idle", int'(start_ready), 1);
        @(posedge clk);
        #1;
        if (v.poke) begin
            vl = VL_W'(9); vsew_in = 2'd3; uses_vs3 = ~v.vs3; wb_en = ~v.wb;
            vs1_base = 5'd0; vd_base = 5'd0;
        end else begin
            start_valid = 1'b0;
        end
        seen_done = 1'b0;
        for (int k = 1; k <= 64 && !seen_done; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("vsew_latched", int'(vsew), v.vsew);
                chk("widening_latched", int'(widening_op), int'(v.wid));
            end
            if (iq.size() > 0 && iq[0].cyc == k) begin
                e = iq.pop_front();
                chk("issue_vs1", int'(vs1_addr), e.a);
                chk("issue_vs2", int'(vs2_addr), e.b);
                if (v.vs3) chk("issue_vd_held", int'(vd_addr), e.c);
            end
            if (write) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", int'(write), 0);
                end else begin
                    e = wq.pop_front();
                    chk("write_cycle", k, e.cyc);
                    chk("write_vd", int'(vd_addr), e.c);
                    chk("write_e2w", int'(elements_to_write), e.a);
                end
            end else if (wq.size() > 0 && wq[0].cyc == k) begin
                chk("write_missing", int'(write), 1);
                void'(wq.pop_front());
            end
            if (done) begin
                seen_done = 1'b1;
                chk("done_cycle", k, v.exp_done);
                chk("err", int'(err), int'(v.exp_err));
                start_valid = 1'b0;
            end else begin
                chk("ready_busy", int'(start_ready), 0);
            end
        end
        if (!seen_done) chk("done_timeout", int'(done), 1);
        start_valid = 1'b0;
        chk("queues_drained", wq.size() + iq.size(), 0);
        @(negedge clk);
        chk("ready_after_done", int'(start_ready), 1);
        chk("done_one_cycle", int'(done), 0);
    endtask

    initial begin
        vec_t v;
        int   nwr;
        //          vl vsew wid vs3 wb  b1  b2  bd poke done err
        vecs[0] = '{ 8, 0, 0, 0, 1,  4,  8, 12, 0,  4, 0};
        vecs[1] = '{ 6, 1, 0, 0, 1,  0,  2,  4, 0,  4, 0};
        vecs[2] = '{ 5, 2, 0, 0, 1,  0,  8, 16, 0,  4, 0};
        vecs[3] = '{ 4, 0, 1, 1, 1,  2,  3,  8, 0,  3, 0};
        vecs[4] = '{ 8, 3, 0, 0, 1,  1,  2,  3, 0,  1, 1};
        vecs[5] = '{ 8, 2, 1, 0, 1,  1,  2,  3, 0,  1, 1};
        vecs[6] = '{ 0, 0, 0, 0, 1,  1,  2,  3, 0,  1, 0};
        vecs[7] = '{13, 0, 0, 1, 0,  5,  6,  7, 0,  9, 0};
        vecs[8] = '{32, 0, 1, 0, 1, 30, 31, 28, 1, 10, 0};
        vecs[9] = '{ 3, 1, 0, 1, 1, 10, 20, 30, 0,  3, 0};

        n_reset = 1'b0;
        start_valid = 1'b0; vl = '0; vsew_in = 2'd0; widening_in = 1'b0;
        uses_vs3 = 1'b0; wb_en = 1'b0; vs1_base = 5'd0; vs2_base = 5'd0; vd_base = 5'd0;
`ifdef VSEQ_STALL_EN
        pe_stall = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(start_ready), 1);
        chk("rst_write", int'(write), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_vs1", int'(vs1_addr), 0);
        n_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            cur = i;
            run(vecs[i]);
        end

        // Reset during ISSUE of a 16-element op: abort immediately, no done.
        cur = 100;
        v = '{16, 0, 0, 0, 1, 1, 2, 3, 0, 6, 0};
        drive(v);
        @(posedge clk);
        #1 start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_write_before", int'(write), 1);
        n_reset = 1'b0;
        #1;
        chk("abort_write", int'(write), 0);
        chk("abort_ready", int'(start_ready), 1);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        n_reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort_no_write", int'(write), 0);
            chk("abort_no_done", int'(done), 0);
        end
        cur = 101;
        run(vecs[0]);

`ifdef VSEQ_STALL_EN
        // Three stalled cycles mid-stream push every later event back by three.
        cur = 200;
        v = '{16, 0, 0, 0, 1, 1, 2, 3, 0, 9, 0};
        drive(v);
        nwr = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            start_valid = 1'b0;
            pe_stall = (k >= 3) && (k <= 5);
            @(negedge clk);
            if (pe_stall) begin
                chk("stall_write", int'(write), 0);
                chk("stall_vs1_frozen", int'(vs1_addr), 3);
                chk("stall_done", int'(done), 0);
            end
            if (write) begin
                chk("stall_write_vd", int'(vd_addr), 3 + nwr);
                nwr++;
            end
            if (done) begin
                chk("stall_done_cycle", k, 9);
                break;
            end
        end
        pe_stall = 1'b0;
        chk("stall_write_count", nwr, 4);
        @(negedge clk);
        chk("stall_ready_after", int'(start_ready), 1);
`else
        nwr = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
